// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the VGA pixel stage.
// Produces hpos/vpos, display_on, hsync/vsync and line/frame end strobes.
// Every output is registered and decoded from the next counter values, so all
// outputs describe the same pixel position in the same cycle.
// Optional feature: define VGA_FRAME_CNT_EN to build the 8-bit frame counter;
// without it frame_cnt is tied to zero.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_NEG  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Counters are 10 bits wide, so larger rasters cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    // Compare constants. Range bounds are 11 bits so an end-of-range value of
    // exactly 1024 is still representable.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_STOP  = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_STOP  = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic        SYNC_ACTIVE = !SYNC_NEG;

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       display_on_q, display_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_end_q, line_end_d;
    logic       frame_end_q, frame_end_d;

    // Next raster position: advance one pixel per enabled cycle, wrapping line and frame.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (pix_en) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end
    end

    // Decode the next position so the registered outputs line up with hpos/vpos.
    always_comb begin
        display_on_d = ({1'b0, hpos_d} < H_VIS) && ({1'b0, vpos_d} < V_VIS);
        hsync_d      = (({1'b0, hpos_d} >= HS_START) && ({1'b0, hpos_d} < HS_STOP))
                       ? SYNC_ACTIVE : !SYNC_ACTIVE;
        vsync_d      = (({1'b0, vpos_d} >= VS_START) && ({1'b0, vpos_d} < VS_STOP))
                       ? SYNC_ACTIVE : !SYNC_ACTIVE;
        line_end_d   = (hpos_d == H_LAST);
        frame_end_d  = (hpos_d == H_LAST) && (vpos_d == V_LAST);
    end

    // Position and timing registers; reset wins over pix_en and lands on (0,0) at once.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            hpos_q       <= '0;
            vpos_q       <= '0;
            display_on_q <= 1'b1;
            hsync_q      <= !SYNC_ACTIVE;
            vsync_q      <= !SYNC_ACTIVE;
            line_end_q   <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            display_on_q <= display_on_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            line_end_q   <= line_end_d;
            frame_end_q  <= frame_end_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign display_on = display_on_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign line_end   = line_end_q;
    assign frame_end  = frame_end_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Count frames on the (last,last) -> (0,0) wrap; 8-bit overflow wraps naturally.
    always_comb begin
        frame_cnt_d = (pix_en && frame_end_q) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    // Frame counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
